// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types, width helpers and output reduction helper for
// the matmul_sequencer block.
package matmul_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_MAC  = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Width of a row/column/inner index for an n x n product (IDX_W)
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  // Width of the operand load counter covering both matrices (LD_W)
  function automatic int ld_w(input int n);
    return $clog2(2 * n * n);
  endfunction

  // Accumulator width that can hold n full-width products without overflow
  function automatic int acc_w(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  // True when value does not fit in out_w unsigned bits
  function automatic logic sat_ovf(input logic [63:0] value, input int out_w);
    return (value >> out_w) != 64'd0;
  endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// matmul_mac_unit: the single shared element multiplier feeding a registered
// accumulator. clr has priority over en; the accumulator holds otherwise.
module matmul_mac_unit
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  logic [PROD_W-1:0]    prod;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH-1:0] acc_q;

  // Full-width product, then clear / accumulate / hold selection
  always_comb begin
    prod  = PROD_W'(a) * PROD_W'(b);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_WIDTH'(prod);
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: loads A then B (row-major) into local storage, computes
// each C element with N multiply-accumulate cycles on the shared MAC unit,
// and streams C row-major over a valid/ready handshake.
// Optional build macro MATMUL_SEQUENCER_SATURATE_EN: saturate C elements to
// OUT_WIDTH instead of truncating them.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int N          = 2,
  parameter int OUT_WIDTH  = DATA_WIDTH + 4,
  parameter int ACC_WIDTH  = acc_w(DATA_WIDTH, N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  busy
);

  localparam int IDX_W = idx_w(N);
  localparam int LD_W  = ld_w(N);
  localparam int NELEM = 2 * N * N;
  localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(NELEM - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_e               state_q, state_d;
  logic [LD_W-1:0]      load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0]     i_q, i_d;
  logic [IDX_W-1:0]     j_q, j_d;
  logic [IDX_W-1:0]     k_q, k_d;
  logic [DATA_WIDTH-1:0] mem_q [NELEM];
  logic                 wr_en;
  logic                 mac_clr;
  logic                 mac_en;
  logic [LD_W-1:0]      a_addr;
  logic [LD_W-1:0]      b_addr;
  logic [DATA_WIDTH-1:0] a_op;
  logic [DATA_WIDTH-1:0] b_op;
  logic [ACC_WIDTH-1:0] acc;

  // Control state and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      load_cnt_q <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
    end
  end

  // Operand storage: A occupies slots 0..N*N-1, B follows; not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[load_cnt_q] <= in_data;
    end
  end

  // Operand fetch for the current A[i][k] * B[k][j] term
  always_comb begin
    a_addr = LD_W'(i_q) * LD_W'(N) + LD_W'(k_q);
    b_addr = LD_W'(N * N) + LD_W'(k_q) * LD_W'(N) + LD_W'(j_q);
    a_op   = mem_q[a_addr];
    b_op   = mem_q[b_addr];
  end

  matmul_mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (mac_clr),
    .en   (mac_en),
    .a    (a_op),
    .b    (b_op),
    .acc  (acc)
  );

  // Next-state, counter and MAC control decode
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    wr_en      = 1'b0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (load_cnt_q == LD_LAST) begin
            load_cnt_d = '0;
            i_d        = '0;
            j_d        = '0;
            k_d        = '0;
            mac_clr    = 1'b1;
            state_d    = ST_MAC;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (k_q == IDX_LAST) begin
          k_d     = '0;
          state_d = ST_EMIT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          mac_clr = 1'b1;
          k_d     = '0;
          if (j_q == IDX_LAST) begin
            j_d = '0;
            if (i_q == IDX_LAST) begin
              i_d        = '0;
              load_cnt_d = '0;
              state_d    = ST_LOAD;
            end else begin
              i_d     = i_q + 1'b1;
              state_d = ST_MAC;
            end
          end else begin
            j_d     = j_q + 1'b1;
            state_d = ST_MAC;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // The accumulator register is the output register: it is loaded with the
  // final sum on MAC exit and frozen until the element is accepted.
  always_comb begin
`ifdef MATMUL_SEQUENCER_SATURATE_EN
    out_data = sat_ovf(64'(acc), OUT_WIDTH) ? '1 : OUT_WIDTH'(acc);
`else
    out_data = OUT_WIDTH'(acc);
`endif
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_EMIT);
  assign busy      = !((state_q == ST_LOAD) && (load_cnt_q == '0));

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed and randomized matrices checked against a
// plain arithmetic matrix-product model, plus handshake/latency/reset checks.
module tb_matmul_sequencer;

  localparam int N  = 2;
  localparam int DW = 4;
  localparam int OW = DW + 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  int a_m [N][N];
  int b_m [N][N];
  int exp_c [N*N];

  always #5 clk = ~clk;

  matmul_sequencer #(
    .DATA_WIDTH(DW),
    .N         (N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: C = A x B with plain integer arithmetic, then output reduction
  function automatic int reduce(input int sum);
`ifdef MATMUL_SEQUENCER_SATURATE_EN
    return (sum > (1 << OW) - 1) ? (1 << OW) - 1 : sum;
`else
    return sum % (1 << OW);
`endif
  endfunction

  task automatic compute_expected();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        int sum = 0;
        for (int t = 0; t < N; t++) sum += a_m[r][t] * b_m[t][c];
        exp_c[r*N + c] = reduce(sum);
      end
    end
  endtask

  task automatic randomize_mats();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        a_m[r][c] = int'($urandom_range(0, (1 << DW) - 1));
        b_m[r][c] = int'($urandom_range(0, (1 << DW) - 1));
      end
    end
  endtask

  // gap_mode: 0 = back-to-back beats, 1 = one idle cycle between beats, 2 = random idles
  task automatic load_mats(input int gap_mode);
    compute_expected();
    for (int idx = 0; idx < 2*N*N; idx++) begin
      int g;
      int e;
      g = 0;
      if (idx != 0) begin
        if (gap_mode == 1) g = 1;
        else if (gap_mode == 2) g = int'($urandom_range(0, 2));
      end
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        @(posedge clk); #1;
      end
      check($sformatf("busy_load%0d", idx), 64'(busy), 64'(idx != 0));
      check($sformatf("in_ready_load%0d", idx), 64'(in_ready), 64'd1);
      e = (idx < N*N) ? idx : idx - N*N;
      in_valid = 1'b1;
      in_data  = (idx < N*N) ? DW'(a_m[e/N][e%N]) : DW'(b_m[e/N][e%N]);
      if (idx != 2*N*N - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Counts edges until out_valid; in_ready must stay low and in_valid is junk
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!out_valid) check("in_ready_busy", 64'(in_ready), 64'd0);
      in_data = DW'($urandom);
    end while (!out_valid && n < 64);
    check("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic collect(input int stall_at, input int stall_len, input string tag);
    int n;
    out_ready = 1'b1;
    for (int e = 0; e < N*N; e++) begin
      wait_valid(n);
      check($sformatf("%s_latency_c%0d", tag, e), 64'(n), 64'(N + 1));
      check($sformatf("%s_data_c%0d", tag, e), 64'(out_data), 64'(exp_c[e]));
      if (e == stall_at) begin
        out_ready = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
          check($sformatf("%s_stall_valid", tag), 64'(out_valid), 64'd1);
          check($sformatf("%s_stall_data", tag), 64'(out_data), 64'(exp_c[e]));
        end
        out_ready = 1'b1;
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s_end_out_valid", tag), 64'(out_valid), 64'd0);
    check($sformatf("%s_end_in_ready", tag), 64'(in_ready), 64'd1);
    check($sformatf("%s_end_busy", tag), 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known product 19,22,43,50
    a_m = '{'{1, 2}, '{3, 4}};
    b_m = '{'{5, 6}, '{7, 8}};
    load_mats(0);
    check("t1_model_c0", 64'(exp_c[0]), 64'd19);
    collect(-1, 0, "t1");

    // All-ones operands: 450 reduced to OUT_WIDTH
    a_m = '{'{15, 15}, '{15, 15}};
    b_m = '{'{15, 15}, '{15, 15}};
    load_mats(0);
    collect(-1, 0, "t2");

    // Identity A, consumer stalls on the second element
    a_m = '{'{1, 0}, '{0, 1}};
    b_m = '{'{9, 3}, '{0, 12}};
    load_mats(0);
    collect(1, 5, "t3");

    // Alternating in_valid during load
    randomize_mats();
    load_mats(1);
    collect(-1, 0, "t4");

    // Reset during MAC of the second element, then a fresh load
    a_m = '{'{1, 2}, '{3, 4}};
    b_m = '{'{5, 6}, '{7, 8}};
    load_mats(0);
    out_ready = 1'b1;
    wait_valid(n);
    check("t5_first", 64'(out_data), 64'd19);
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t5_rst_out_valid", 64'(out_valid), 64'd0);
    check("t5_rst_in_ready", 64'(in_ready), 64'd1);
    check("t5_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_mats(0);
    collect(-1, 0, "t5");

    // Two matrices back to back
    randomize_mats();
    load_mats(0);
    collect(-1, 0, "t6a");
    randomize_mats();
    load_mats(0);
    collect(-1, 0, "t6b");

    // Randomized matrices, load gaps and consumer stalls
    for (int it = 0; it < 4; it++) begin
      randomize_mats();
      load_mats(2);
      collect(int'($urandom_range(0, N*N - 1)), int'($urandom_range(0, 3)),
              $sformatf("rnd%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
